pll_lock_ctrl: RTL and testbench

Sequencer for the FSK transmitter's clock PLL (16 MHz reference in, 5 MHz out). It runs on the free-running 16 MHz reference clock, not the PLL output. It pulses the PLL reset, waits for LOCK with a timeout and bounded retries, and qualifies lock as stable before enabling the transmitter. It detects loss of lock in service and recovers from it, and reports a hard failure.

---
 rtl/pll_ctrl_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock sequencer: state encodings and default
// timing constants.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pll_state_t;

   localparam int DEF_RST_CYCLES   = 16;
   localparam int DEF_LOCK_TIMEOUT = 16000;
   localparam int DEF_LOCK_STABLE  = 64;
   localparam int DEF_MAX_RETRIES  = 3;
   localparam int DEF_CNT_W        = 16;
   localparam int LOSS_W           = 8;
   localparam int RETRY_W          = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal crossing into clk_in.
module sync_2ff (
   input  logic clk_in,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses PLL reset, qualifies LOCK with timeout and
// bounded retries, and gates the transmitter while lock is held.
module pll_lock_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int RST_CYCLES   = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
   parameter int MAX_RETRIES  = DEF_MAX_RETRIES,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic               pll_lock,
   input  logic               restart,
   output logic               pll_rst,
   output logic               tx_enable,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [LOSS_W-1:0]  loss_cnt,
   output logic [2:0]         state_dbg
);

   localparam int STAB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE + 1) : 1;
   localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(LOCK_STABLE - 1);
   localparam logic [RETRY_W-1:0] MAX_R     = RETRY_W'(MAX_RETRIES);

   if (MAX_RETRIES > 3 || MAX_RETRIES < 0) begin : g_bad_retries
      $error("pll_lock_ctrl: MAX_RETRIES must fit the 2-bit retry_cnt");
   end
   if (RST_CYCLES < 1 || LOCK_STABLE < 1 || LOCK_TIMEOUT < 1) begin : g_bad_timing
      $error("pll_lock_ctrl: RST_CYCLES, LOCK_STABLE and LOCK_TIMEOUT must be >= 1");
   end
   if (RST_CYCLES > 2**CNT_W || LOCK_TIMEOUT > 2**CNT_W) begin : g_bad_cnt_w
      $error("pll_lock_ctrl: CNT_W too narrow for RST_CYCLES/LOCK_TIMEOUT");
   end

   pll_state_t          state, state_nxt;
   logic [CNT_W-1:0]    timer, timer_nxt, timer_inc;
   logic [STAB_W-1:0]   stab, stab_nxt;
   logic [RETRY_W-1:0]  retry, retry_nxt;
   logic [LOSS_W-1:0]   loss, loss_nxt;
   logic                lock_s;
   logic                timed_out;

   sync_2ff u_lock_sync (
      .clk_in (clk_in),
      .reset  (reset),
      .d      (pll_lock),
      .q      (lock_s)
   );

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state <= RESET_PLL;
         timer <= '0;
         stab  <= '0;
         retry <= '0;
         loss  <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         stab  <= stab_nxt;
         retry <= retry_nxt;
         loss  <= loss_nxt;
      end
   end

   // Timer saturates so an over-long STABLE/WAIT dwell can never wrap past the timeout.
   assign timer_inc = (timer == '1) ? timer : timer + CNT_W'(1);
   assign timed_out = (timer >= TO_LAST);

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      stab_nxt  = stab;
      retry_nxt = retry;
      loss_nxt  = loss;

      case (state)
         RESET_PLL: begin
            if (timer >= RST_LAST) begin
               state_nxt = WAIT_LOCK;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer_inc;
            end
         end
         WAIT_LOCK: begin
            timer_nxt = timer_inc;
            if (lock_s) begin
               state_nxt = STABLE;
               stab_nxt  = STAB_W'(1);
            end else if (timed_out) begin
               timer_nxt = '0;
               stab_nxt  = '0;
               if (retry < MAX_R) begin
                  retry_nxt = retry + RETRY_W'(1);
                  state_nxt = RESET_PLL;
               end else begin
                  state_nxt = FAIL;
               end
            end
         end
         STABLE: begin
            timer_nxt = timer_inc;
            // Completion is checked first so it beats a coincident timeout.
            if (lock_s && stab >= STAB_LAST) begin
               state_nxt = RUN;
               timer_nxt = '0;
               stab_nxt  = '0;
            end else if (timed_out) begin
               timer_nxt = '0;
               stab_nxt  = '0;
               if (retry < MAX_R) begin
                  retry_nxt = retry + RETRY_W'(1);
                  state_nxt = RESET_PLL;
               end else begin
                  state_nxt = FAIL;
               end
            end else if (lock_s) begin
               stab_nxt = stab + STAB_W'(1);
            end else begin
               stab_nxt  = '0;
               state_nxt = WAIT_LOCK;
            end
         end
         RUN: begin
            if (!lock_s) begin
               loss_nxt  = (loss == '1) ? loss : loss + LOSS_W'(1);
               retry_nxt = '0;
               timer_nxt = '0;
               state_nxt = RESET_PLL;
            end
         end
         FAIL: begin
            state_nxt = FAIL;
         end
         default: begin
            state_nxt = RESET_PLL;
            timer_nxt = '0;
            stab_nxt  = '0;
         end
      endcase

      if (restart) begin
         state_nxt = RESET_PLL;
         timer_nxt = '0;
         stab_nxt  = '0;
         retry_nxt = '0;
         loss_nxt  = loss;
      end
   end

   assign pll_rst   = (state == RESET_PLL) || (state == FAIL);
   assign tx_enable = (state == RUN);
   assign fail      = (state == FAIL);
   assign retry_cnt = retry;
   assign loss_cnt  = loss;
   assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: directed table, multi-cycle corner sequences and a
// randomized run, all checked against a cycle-level reference model.
module tb_pll_lock_ctrl;

   localparam int RSTC = 4;
   localparam int TO   = 20;
   localparam int STAB = 5;
   localparam int MAXR = 2;

   logic       clk_in = 1'b0;
   logic       reset = 1'b0;
   logic       pll_lock = 1'b0;
   logic       restart = 1'b0;
   logic       pll_rst, tx_enable, fail;
   logic [1:0] retry_cnt;
   logic [7:0] loss_cnt;
   logic [2:0] state_dbg;

   int checks = 0;
   int passes = 0;

   // Reference model: phase (0 reset pulse, 1 waiting, 2 qualifying, 3 run,
   // 4 failed), timer as elapsed edges since m_t0, lock history as a queue.
   int m_st, m_t0, m_run, m_retry, m_loss, cyc;
   bit sq[$];

   always #5 clk_in = ~clk_in;

   pll_lock_ctrl #(
      .RST_CYCLES   (RSTC),
      .LOCK_TIMEOUT (TO),
      .LOCK_STABLE  (STAB),
      .MAX_RETRIES  (MAXR),
      .CNT_W        (16)
   ) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .pll_lock  (pll_lock),
      .restart   (restart),
      .pll_rst   (pll_rst),
      .tx_enable (tx_enable),
      .fail      (fail),
      .retry_cnt (retry_cnt),
      .loss_cnt  (loss_cnt),
      .state_dbg (state_dbg)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
   endtask

   task automatic model_reset();
      m_st = 0; m_t0 = cyc + 1; m_run = 0; m_retry = 0; m_loss = 0;
      sq.delete();
      sq.push_back(1'b0);
      sq.push_back(1'b0);
   endtask

   task automatic model_timeout();
      m_run = 0;
      if (m_retry < MAXR) begin
         m_retry++; m_st = 0; m_t0 = cyc + 1;
      end else begin
         m_st = 4;
      end
   endtask

   task automatic model_edge();
      bit ls;
      int el;
      cyc++;
      el = cyc - m_t0;
      ls = sq.pop_front();
      sq.push_back(pll_lock);
      if (restart) begin
         m_st = 0; m_t0 = cyc + 1; m_run = 0; m_retry = 0;
      end else begin
         case (m_st)
            0: if (el >= RSTC - 1) begin m_st = 1; m_t0 = cyc + 1; end
            1: if (ls) begin m_st = 2; m_run = 1; end
               else if (el >= TO - 1) model_timeout();
            2: if (ls && m_run + 1 >= STAB) begin m_st = 3; m_run = 0; end
               else if (el >= TO - 1) model_timeout();
               else if (ls) m_run++;
               else begin m_run = 0; m_st = 1; end
            3: if (!ls) begin
                  if (m_loss < 255) m_loss++;
                  m_retry = 0; m_st = 0; m_t0 = cyc + 1;
               end
            default: ;
         endcase
      end
   endtask

   function automatic int exp_vec();
      bit pr, tx, fl;
      pr = (m_st == 0) || (m_st == 4);
      tx = (m_st == 3);
      fl = (m_st == 4);
      return int'({pr, tx, fl, 2'(m_retry), 8'(m_loss), 3'(m_st)});
   endfunction

   task automatic tick();
      @(posedge clk_in);
      if (reset) model_edge();
      @(negedge clk_in);
      chk("model", int'({pll_rst, tx_enable, fail, retry_cnt, loss_cnt, state_dbg}), exp_vec());
   endtask

   task automatic do_reset(input bit lock_val);
      reset = 1'b0; restart = 1'b0; pll_lock = lock_val;
      model_reset();
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic wait_state(input int st, input int budget, input string nm);
      int n = 0;
      while (int'(state_dbg) != st && n < budget) begin
         tick();
         n++;
      end
      chk(nm, int'(state_dbg), st);
   endtask

   typedef struct {
      bit lock;
      int n;
      bit pr, tx, fl;
      int retry;
      int st;
   } vec_t;

   initial begin
      vec_t tbl[8];
      bit   s[81];
      int   r[81];
      int   errs;
      bit   saw_tx, saw_stable;
      int   hold;

      cyc = 0;
      model_reset();
      tick();
      chk("rst_pll_rst", int'(pll_rst), 1);
      chk("rst_tx", int'(tx_enable), 0);
      chk("rst_fail", int'(fail), 0);
      chk("rst_state", int'(state_dbg), 0);
      chk("rst_retry", int'(retry_cnt), 0);
      chk("rst_loss", int'(loss_cnt), 0);

      // Test 1: normal lock-up, lock rises 10 cycles after pll_rst falls
      tbl[0] = '{0, 3,  1, 0, 0, 0, 0};
      tbl[1] = '{0, 1,  0, 0, 0, 0, 1};
      tbl[2] = '{0, 10, 0, 0, 0, 0, 1};
      tbl[3] = '{1, 2,  0, 0, 0, 0, 1};
      tbl[4] = '{1, 1,  0, 0, 0, 0, 2};
      tbl[5] = '{1, 3,  0, 0, 0, 0, 2};
      tbl[6] = '{1, 1,  0, 1, 0, 0, 3};
      tbl[7] = '{1, 10, 0, 1, 0, 0, 3};
      do_reset(1'b0);
      for (int i = 0; i < 8; i++) begin
         pll_lock = tbl[i].lock;
         repeat (tbl[i].n) tick();
         chk($sformatf("t1[%0d].pll_rst", i), int'(pll_rst), int'(tbl[i].pr));
         chk($sformatf("t1[%0d].tx", i), int'(tx_enable), int'(tbl[i].tx));
         chk($sformatf("t1[%0d].fail", i), int'(fail), int'(tbl[i].fl));
         chk($sformatf("t1[%0d].retry", i), int'(retry_cnt), tbl[i].retry);
         chk($sformatf("t1[%0d].state", i), int'(state_dbg), tbl[i].st);
      end

      // Test 3: repeated one-cycle lock drops in RUN, loss_cnt saturates
      for (int i = 0; i < 300; i++) begin
         pll_lock = 1'b0;
         tick();
         pll_lock = 1'b1;
         tick();
         if (i == 0) chk("t3_tx_still_on", int'(tx_enable), 1);
         tick();
         if (i == 0) begin
            chk("t3_tx_off", int'(tx_enable), 0);
            chk("t3_loss1", int'(loss_cnt), 1);
            chk("t3_state_rst", int'(state_dbg), 0);
         end
         wait_state(3, 40, "t3_relock");
      end
      chk("t3_loss_sat", int'(loss_cnt), 255);

      // Test 6: async reset in the middle of WAIT_LOCK
      pll_lock = 1'b0;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      repeat (6) tick();
      chk("t6_in_wait", int'(state_dbg), 1);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_pll_rst", int'(pll_rst), 1);
      chk("t6_async_tx", int'(tx_enable), 0);
      chk("t6_async_state", int'(state_dbg), 0);
      chk("t6_async_loss", int'(loss_cnt), 0);
      chk("t6_async_retry", int'(retry_cnt), 0);
      model_reset();
      tick();
      reset = 1'b1;
      pll_lock = 1'b1;
      wait_state(3, 40, "t6_relock");
      chk("t6_retry", int'(retry_cnt), 0);

      // Test 2: lock never arrives -> three attempts then FAIL
      do_reset(1'b0);
      s[0] = pll_rst;
      r[0] = int'(retry_cnt);
      for (int n = 1; n <= 80; n++) begin
         tick();
         s[n] = pll_rst;
         r[n] = int'(retry_cnt);
      end
      errs = 0;
      for (int n = 0; n <= 80; n++) begin
         bit e;
         e = (n < 4) || (n >= 24 && n < 28) || (n >= 48 && n < 52) || (n >= 72);
         if (s[n] != e) errs++;
      end
      chk("t2_pll_rst_pattern", errs, 0);
      chk("t2_retry_a", r[23], 0);
      chk("t2_retry_b", r[24], 1);
      chk("t2_retry_c", r[47], 1);
      chk("t2_retry_d", r[48], 2);
      chk("t2_fail", int'(fail), 1);
      chk("t2_state", int'(state_dbg), 4);
      chk("t2_tx", int'(tx_enable), 0);

      // Test 5a: restart out of FAIL
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("t5_state", int'(state_dbg), 0);
      chk("t5_fail_clr", int'(fail), 0);
      chk("t5_retry_clr", int'(retry_cnt), 0);
      chk("t5_pll_rst", int'(pll_rst), 1);
      pll_lock = 1'b1;
      wait_state(3, 40, "t5_run");

      // Test 5b: restart coincident with lock loss in RUN
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("t5b_state", int'(state_dbg), 0);
      chk("t5b_loss_unchanged", int'(loss_cnt), 0);
      chk("t5b_retry", int'(retry_cnt), 0);
      chk("t5b_tx", int'(tx_enable), 0);

      // Test 4: chattering lock during qualification times out
      do_reset(1'b1);
      saw_tx = 1'b0;
      saw_stable = 1'b0;
      for (int n = 1; n <= 24; n++) begin
         pll_lock = (((n - 1) / 3) % 2) == 0;
         tick();
         if (tx_enable) saw_tx = 1'b1;
         if (state_dbg == 3'd2) saw_stable = 1'b1;
         if (n == 23) chk("t4_before_timeout", int'(state_dbg == 3'd0), 0);
      end
      chk("t4_no_run", int'(saw_tx), 0);
      chk("t4_saw_stable", int'(saw_stable), 1);
      chk("t4_timeout_state", int'(state_dbg), 0);
      chk("t4_retry", int'(retry_cnt), 1);

      // Randomized lock behaviour with occasional restarts
      hold = 0;
      for (int n = 0; n < 1500; n++) begin
         if (hold == 0) begin
            pll_lock = ~pll_lock;
            hold = pll_lock ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 8));
         end
         hold--;
         restart = ($urandom_range(0, 63) == 0);
         tick();
      end
      restart = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
